// File: rtl/pc_seq.sv
// pc_seq: fetch-side PC sequencer; owns the F-stage PC, tracks delay slots,
// and redirects fetch for branches, exception entry and eret.
module pc_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] target,
    input  logic        dclr,
    input  logic        exc,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        flush_d,
    output logic        slot_f,
    output logic        slot_d
);
    typedef enum logic {SEQ = 1'b0, SLOT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d, pc_d_q, pc_d_d;
    logic        slot_d_q, slot_d_d;
    logic        redirect, adv;
    logic        unused_bits;

    assign unused_bits = ^{target[1:0], epc[1:0]};

    always_comb begin
        redirect = exc | eret;
        adv      = redirect | ~stall;
        flush_d  = redirect | (dclr & ~stall);
        pc_f_d   = exc   ? EXC_VEC :
                   eret  ? {epc[31:2], 2'b00} :
                   stall ? pc_f_q :
                   br    ? {target[31:2], 2'b00} :
                           pc_f_q + 32'd4;
        // A delay slot never opens another slot window, even with br high.
        state_d  = redirect ? SEQ :
                   stall    ? state_q :
                   (br && state_q == SEQ) ? SLOT : SEQ;
        pc_d_d   = adv ? pc_f_q : pc_d_q;
        slot_d_d = flush_d ? 1'b0 : adv ? (state_q == SLOT) : slot_d_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SEQ;
            pc_f_q   <= RESET_PC;
            pc_d_q   <= 32'd0;
            slot_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_f_q   <= pc_f_d;
            pc_d_q   <= pc_d_d;
            slot_d_q <= slot_d_d;
        end
    end

    assign pc_f   = pc_f_q;
    assign pc_d   = pc_d_q;
    assign pc8_d  = pc_d_q + 32'd8;
    assign slot_f = (state_q == SLOT);
    assign slot_d = slot_d_q;
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized scoreboard bench for pc_seq against a behavioural model.
module tb_pc_seq;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset, stall, br, dclr, exc, eret;
    logic [31:0] target, epc;
    logic [31:0] pc_f, pc_d, pc8_d;
    logic        flush_d, slot_f, slot_d;

    pc_seq dut (
        .clk(clk), .reset(reset), .stall(stall), .br(br), .target(target),
        .dclr(dclr), .exc(exc), .eret(eret), .epc(epc),
        .pc_f(pc_f), .pc_d(pc_d), .pc8_d(pc8_d),
        .flush_d(flush_d), .slot_f(slot_f), .slot_d(slot_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf, pcd, pc8;
        logic        fl, sf, sd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Architectural model state: what is in F and D, and whether each is a delay slot.
    logic [31:0] m_pcf = RST_PC, m_pcd = 32'd0;
    logic        m_sf = 1'b0, m_sd = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, a, x, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_f", pc_f, e.pcf);
                chk("pc_d", pc_d, e.pcd);
                chk("pc8_d", pc8_d, e.pc8);
                chk("flush_d", {31'd0, flush_d}, {31'd0, e.fl});
                chk("slot_f", {31'd0, slot_f}, {31'd0, e.sf});
                chk("slot_d", {31'd0, slot_d}, {31'd0, e.sd});
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic b, input logic dc,
                        input logic e, input logic er,
                        input logic [31:0] t, input logic [31:0] ep);
        exp_t        x;
        logic [31:0] npcf, npcd;
        logic        nsf, nsd, moves, kill;
        reset = r; stall = s; br = b; dclr = dc; exc = e; eret = er; target = t; epc = ep;
        if (!r) begin
            m_pcf = RST_PC; m_pcd = 32'd0; m_sf = 1'b0; m_sd = 1'b0;
        end
        kill  = e | er | (dc & ~s);
        moves = e | er | ~s;
        x.pcf = m_pcf; x.pcd = m_pcd; x.pc8 = m_pcd + 32'd8;
        x.fl = kill; x.sf = m_sf; x.sd = m_sd;
        q.push_back(x);
        if (!r) begin
            npcf = RST_PC; npcd = 32'd0; nsf = 1'b0; nsd = 1'b0;
        end else begin
            if (e)       npcf = EXC_PC;
            else if (er) npcf = ep & 32'hFFFF_FFFC;
            else if (s)  npcf = m_pcf;
            else if (b)  npcf = t & 32'hFFFF_FFFC;
            else         npcf = m_pcf + 32'd4;
            if (e || er) nsf = 1'b0;
            else if (s)  nsf = m_sf;
            else         nsf = b && !m_sf;
            npcd = moves ? m_pcf : m_pcd;
            nsd  = kill ? 1'b0 : (moves ? m_sf : m_sd);
        end
        @(posedge clk);
        #1;
        m_pcf = npcf; m_pcd = npcd; m_sf = nsf; m_sd = nsd;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin : driver
        reset = 1'b0; stall = 1'b0; br = 1'b0; dclr = 1'b0;
        exc = 1'b0; eret = 1'b0; target = 32'd0; epc = 32'd0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 1, 1, 1, 0, 0, 32'h1234, 32'd0);
        plain(4);
        step(1, 0, 1, 0, 0, 0, 32'h0000_3103, 32'd0);
        plain(3);
        step(1, 1, 1, 0, 0, 0, 32'h0000_3100, 32'd0);
        step(1, 1, 1, 0, 0, 0, 32'h0000_3100, 32'd0);
        step(1, 0, 1, 0, 0, 0, 32'h0000_3100, 32'd0);
        plain(2);
        step(1, 0, 1, 1, 0, 0, 32'h0000_3200, 32'd0);
        plain(2);
        step(1, 1, 0, 1, 1, 0, 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 1, 32'd0, 32'h0000_3022);
        step(1, 0, 0, 0, 1, 1, 32'd0, 32'h0000_3022);
        step(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFB, 32'd0);
        plain(3);
        step(1, 0, 1, 0, 0, 0, 32'h0000_3500, 32'd0);
        step(0, 1, 1, 0, 0, 0, 32'h0000_3600, 32'd0);
        step(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        plain(2);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t, ep;
            t  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(0, 32'h3FF) + 32'h3000);
            ep = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(0, 32'h3FF) + 32'h3000);
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 24) == 0,
                 t, ep);
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
